memory_serial_ctrl: RTL and testbench

Initiator-side controller for the narrow memory units in the interleaved memory subsystem. It accepts full-width word read/write requests over a valid/ready handshake and serialises each one into NUM_MEM_UNITS consecutive unit-wide accesses on a single memory port. The memory port has a registered, one-cycle read latency. For reads, the block reassembles the returned units into one word and presents it on a one-cycle response pulse.

---
 rtl/memory_serial_ctrl.sv | 134 +++++++++++++
 tb/tb_memory_serial_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_serial_ctrl.sv
// Serialises full-width word read/write requests into NUM_MEM_UNITS unit-wide
// accesses on one memory port with a registered one-cycle read latency.
module memory_serial_ctrl #(
    parameter int BUS_SIZE       = 32,
    parameter int ADDR_WIDTH     = 4,
    parameter int NUM_MEM_UNITS  = 4,
    parameter int LANE_BITS      = 2,
    parameter int MEM_UNIT_WIDTH = BUS_SIZE / NUM_MEM_UNITS
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            req_valid,
    input  logic                            req_write,
    input  logic [ADDR_WIDTH-LANE_BITS-1:0] req_addr,
    input  logic [BUS_SIZE-1:0]             req_wdata,
    output logic                            req_ready,
    output logic                            rsp_valid,
    output logic [BUS_SIZE-1:0]             rsp_rdata,
    output logic                            mem_read,
    output logic                            mem_write,
    output logic [ADDR_WIDTH-1:0]           mem_address,
    output logic [MEM_UNIT_WIDTH-1:0]       mem_wdata,
    input  logic [MEM_UNIT_WIDTH-1:0]       mem_rdata
);

    localparam int WORD_BITS = ADDR_WIDTH - LANE_BITS;
    localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(NUM_MEM_UNITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        RESP
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [WORD_BITS-1:0]   addr_q;
    logic [LANE_BITS-1:0]   lane_q;
    logic [LANE_BITS-1:0]   prev_lane;
    logic [BUS_SIZE-1:0]    wdata_q;
    logic [BUS_SIZE-1:0]    rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes and handshakes are forced low while reset is held, even before
    // the first clock edge has cleared the state register.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = ~reset;
                if (req_valid) begin
                    state_d = req_write ? WRITE : READ;
                end
            end
            WRITE: begin
                mem_write = ~reset;
                if (lane_q == LAST_LANE) begin
                    state_d = RESP;
                end
            end
            READ: begin
                mem_read = ~reset;
                if (lane_q == LAST_LANE) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = ~reset;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign prev_lane = lane_q - 1'b1;

    // Read data returns one cycle behind its address, so each READ cycle after
    // the first fills the previous lane and DRAIN fills the last one.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            lane_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    lane_q <= '0;
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                    end
                end
                WRITE: begin
                    lane_q <= lane_q + 1'b1;
                end
                READ: begin
                    lane_q <= lane_q + 1'b1;
                    if (lane_q != '0) begin
                        rdata_q[int'(prev_lane)*MEM_UNIT_WIDTH +: MEM_UNIT_WIDTH] <= mem_rdata;
                    end
                end
                DRAIN: begin
                    rdata_q[(NUM_MEM_UNITS-1)*MEM_UNIT_WIDTH +: MEM_UNIT_WIDTH] <= mem_rdata;
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_address = {addr_q, lane_q};
    assign mem_wdata   = wdata_q[int'(lane_q)*MEM_UNIT_WIDTH +: MEM_UNIT_WIDTH];
    assign rsp_rdata   = rdata_q;

endmodule

// File: tb/tb_memory_serial_ctrl.sv
// Scoreboard bench for memory_serial_ctrl: a word-level reference memory
// predicts responses, a negedge monitor checks strobes, timing and data.
module tb_memory_serial_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_address;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    memory_serial_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    typedef struct {
        bit          w;
        logic [1:0]  word;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          acc;
    } txn_t;

    txn_t        sbq[$];
    logic [31:0] ref_mem [4];
    logic [31:0] model_last;
    logic [7:0]  unit_mem [16];
    bit          fresh_reset;
    int          cyc;
    int          n_cmp;
    int          n_fail;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Unit-wide memory with registered read data.
    initial begin
        mem_rdata = 8'h00;
        for (int i = 0; i < 16; i++) unit_mem[i] = 8'h00;
        forever begin
            @(posedge clk);
            if (mem_read) mem_rdata <= unit_mem[mem_address];
            if (mem_write) unit_mem[mem_address] <= mem_wdata;
        end
    end

    // Stimulus side of the scoreboard: predict the response at acceptance.
    initial begin
        txn_t t;
        for (int i = 0; i < 4; i++) ref_mem[i] = 32'h0;
        model_last  = 32'h0;
        fresh_reset = 1'b1;
        forever begin
            @(posedge clk);
            if (reset) begin
                sbq.delete();
                model_last  = 32'h0;
                fresh_reset = 1'b1;
            end else if (req_valid && req_ready) begin
                fresh_reset = 1'b0;
                t.w     = req_write;
                t.word  = req_addr;
                t.wdata = req_wdata;
                t.acc   = cyc;
                if (req_write) begin
                    t.exp = model_last;
                    ref_mem[req_addr] = req_wdata;
                end else begin
                    t.exp = ref_mem[req_addr];
                    model_last = t.exp;
                end
                sbq.push_back(t);
            end
        end
    end

    // Monitor: checks every cycle against the head of the scoreboard.
    initial begin
        txn_t       t;
        int         k;
        bit         expw;
        bit         expr;
        logic [1:0] ln;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                chk("reset_outs", {28'h0, req_ready, mem_read, mem_write, rsp_valid}, 32'h0);
            end else begin
                chk("ready", req_ready, (sbq.size() == 0) ? 32'h1 : 32'h0);
                chk("strobe_excl", mem_read & mem_write, 32'h0);
                if (sbq.size() == 0) begin
                    chk("idle_strobe", {mem_read, mem_write}, 32'h0);
                    chk("idle_rsp", rsp_valid, 32'h0);
                    chk("idle_rdata", rsp_rdata, model_last);
                    if (fresh_reset) begin
                        chk("reset_addr", mem_address, 32'h0);
                        chk("reset_wdata", mem_wdata, 32'h0);
                    end
                end else begin
                    t    = sbq[0];
                    k    = cyc - t.acc;
                    expw = t.w && k >= 1 && k <= 4;
                    expr = !t.w && k >= 1 && k <= 4;
                    ln   = 2'(k - 1);
                    chk("mem_write", mem_write, {31'h0, expw});
                    chk("mem_read", mem_read, {31'h0, expr});
                    if (expw || expr) chk("mem_address", mem_address, {28'h0, t.word, ln});
                    if (expw) chk("mem_wdata", mem_wdata, t.wdata[ln*8 +: 8]);
                    chk("rsp_valid", rsp_valid, (k == (t.w ? 5 : 6)) ? 32'h1 : 32'h0);
                    if (rsp_valid) begin
                        chk(t.w ? "rsp_hold" : "rsp_rdata", rsp_rdata, t.exp);
                        void'(sbq.pop_front());
                    end else if (k >= 7) begin
                        void'(sbq.pop_front());
                    end
                end
            end
        end
    end

    task automatic issue(input bit w, input logic [1:0] a, input logic [31:0] d, input bit hold);
        bit acc;
        acc       = 1'b0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            if (req_ready && !reset) begin
                acc = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!acc) begin
            n_fail++;
            $display("FAIL accept_timeout at cycle %0d: got no acceptance expected one", cyc);
        end
        #1;
        req_wdata = $urandom;
        if (!hold) begin
            req_valid = 1'b0;
            req_addr  = 2'($urandom_range(0, 3));
            req_write = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (sbq.size() == 0) break;
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog at cycle %0d: got no finish expected finish", cyc);
        $fatal(1);
    end

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 2'd0;
        req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        issue(1'b1, 2'd2, 32'hDEADBEEF, 1'b0);
        wait_idle();
        issue(1'b0, 2'd2, 32'h0, 1'b0);
        wait_idle();
        issue(1'b1, 2'd3, 32'h01234567, 1'b0);
        wait_idle();
        issue(1'b0, 2'd3, 32'h0, 1'b0);
        wait_idle();

        for (int i = 0; i < 6; i++) begin
            issue((i % 2) == 0, 2'(i), $urandom, i < 5);
        end
        wait_idle();

        // Abort a read in its second cycle, then read normally.
        issue(1'b0, 2'd3, 32'h0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        issue(1'b0, 2'd2, 32'h0, 1'b0);
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            bit hold;
            hold = 1'($urandom_range(0, 1));
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, hold);
            if (!hold) repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        wait_idle();
        repeat (4) @(posedge clk);
        chk("queue_empty", sbq.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
